// File: rtl/lcd_ctrl_pkg.sv
// rtl/lcd_ctrl_pkg.sv - shared FSM states and constants for the LCD pattern scheduler
package lcd_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_COMMIT = 2'd2
   } sched_state_t;

   localparam int         MODE_W    = 3;
   localparam logic [5:0] LED_RESET = 6'b111110;

   // One LED lit (driven low) per mode
   function automatic logic [5:0] led_for_mode(input logic [MODE_W-1:0] sel);
      led_for_mode = ~(6'b000001 << sel);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchronizer and debouncer, one-cycle press event on 1->0
module btn_debounce
   import lcd_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 540000
) (
   input  logic CLK_27M,
   input  logic Reset_Button,
   input  logic btn_n,
   output logic press
);

   localparam int             CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_q, press_d;

   always_comb begin
      sync1_d  = btn_n;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;
      press_d  = 1'b0;
      if (sync2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_d = sync2_q;
         cnt_d    = '0;
         press_d  = stable_q & ~sync2_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK_27M or negedge Reset_Button) begin
      if (!Reset_Button) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         stable_q <= 1'b1;
         cnt_q    <= '0;
         press_q  <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         press_q  <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/lcd_pattern_scheduler.sv
// rtl/lcd_pattern_scheduler.sv - button-driven test pattern selector committing on frame boundaries
// Optional automatic advance every AUTO_FRAMES frames: define LCD_AUTO_CYCLE_EN.
module lcd_pattern_scheduler
   import lcd_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 540000,
   parameter int NUM_MODES       = 4,
   parameter int AUTO_FRAMES     = 120
) (
   input  logic       CLK_27M,
   input  logic       Reset_Button,
   input  logic       User_Button,
   input  logic       LCD_VSYNC,
   output logic [2:0] pattern_sel,
   output logic       pattern_upd,
   output logic       busy,
   output logic [5:0] LED
);

   localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);

   if (NUM_MODES < 2 || NUM_MODES > 6 || AUTO_FRAMES < 1) begin : g_bad_params
      $error("lcd_pattern_scheduler: NUM_MODES must be 2..6 and AUTO_FRAMES >= 1");
   end

   logic press;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .CLK_27M      (CLK_27M),
      .Reset_Button (Reset_Button),
      .btn_n        (User_Button),
      .press        (press)
   );

   logic vs_sync1_q, vs_sync1_d;
   logic vs_sync2_q, vs_sync2_d;
   logic vs_prev_q, vs_prev_d;
   logic frame_evt;

   sched_state_t      state_q, state_d;
   logic [MODE_W-1:0] sel_q, sel_d;
   logic              upd_q, upd_d;
   logic              busy_q, busy_d;
   logic [5:0]        led_q, led_d;
   logic [MODE_W-1:0] next_sel;

`ifdef LCD_AUTO_CYCLE_EN
   localparam int                FR_W      = $clog2(AUTO_FRAMES + 1);
   localparam logic [FR_W-1:0]   FR_LAST   = FR_W'(AUTO_FRAMES - 1);
   logic [FR_W-1:0]              frame_cnt_q, frame_cnt_d;
`endif

   assign frame_evt = vs_prev_q & ~vs_sync2_q;
   assign next_sel  = (sel_q == LAST_MODE) ? '0 : sel_q + MODE_W'(1);

   always_comb begin
      vs_sync1_d = LCD_VSYNC;
      vs_sync2_d = vs_sync1_q;
      vs_prev_d  = vs_sync2_q;
      state_d    = state_q;
      sel_d      = sel_q;
      upd_d      = 1'b0;
`ifdef LCD_AUTO_CYCLE_EN
      frame_cnt_d = frame_cnt_q;
`endif
      unique case (state_q)
         // A press wins over a simultaneous frame event; that frame is not the commit frame
         ST_IDLE: begin
            if (press) begin
               state_d = ST_ARMED;
`ifdef LCD_AUTO_CYCLE_EN
               frame_cnt_d = '0;
            end else if (frame_evt) begin
               if (frame_cnt_q == FR_LAST) begin
                  state_d = ST_COMMIT;
               end else begin
                  frame_cnt_d = frame_cnt_q + FR_W'(1);
               end
`endif
            end
         end
         ST_ARMED: begin
            if (frame_evt) begin
               state_d = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (state_d == ST_COMMIT) begin
         sel_d = next_sel;
         upd_d = 1'b1;
`ifdef LCD_AUTO_CYCLE_EN
         frame_cnt_d = '0;
`endif
      end
      busy_d = (state_d == ST_ARMED);
      led_d  = led_for_mode(sel_d);
   end

   always_ff @(posedge CLK_27M or negedge Reset_Button) begin
      if (!Reset_Button) begin
         vs_sync1_q <= 1'b1;
         vs_sync2_q <= 1'b1;
         vs_prev_q  <= 1'b1;
         state_q    <= ST_IDLE;
         sel_q      <= '0;
         upd_q      <= 1'b0;
         busy_q     <= 1'b0;
         led_q      <= LED_RESET;
`ifdef LCD_AUTO_CYCLE_EN
         frame_cnt_q <= '0;
`endif
      end else begin
         vs_sync1_q <= vs_sync1_d;
         vs_sync2_q <= vs_sync2_d;
         vs_prev_q  <= vs_prev_d;
         state_q    <= state_d;
         sel_q      <= sel_d;
         upd_q      <= upd_d;
         busy_q     <= busy_d;
         led_q      <= led_d;
`ifdef LCD_AUTO_CYCLE_EN
         frame_cnt_q <= frame_cnt_d;
`endif
      end
   end

   assign pattern_sel = sel_q;
   assign pattern_upd = upd_q;
   assign busy        = busy_q;
   assign LED         = led_q;

endmodule

// File: tb/tb_lcd_pattern_scheduler.sv
// tb/tb_lcd_pattern_scheduler.sv - self-checking bench for lcd_pattern_scheduler
module tb_lcd_pattern_scheduler;

   localparam int NUM_MODES = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn = 1'b1;
   logic       vsync = 1'b1;
   logic [2:0] pattern_sel;
   logic       pattern_upd;
   logic       busy;
   logic [5:0] led;

   int total = 0;
   int passed = 0;
   int upd_total = 0;

   always #5 clk = ~clk;

   lcd_pattern_scheduler #(
      .DEBOUNCE_CYCLES (16),
      .NUM_MODES       (NUM_MODES),
      .AUTO_FRAMES     (3)
   ) dut (
      .CLK_27M      (clk),
      .Reset_Button (rst_n),
      .User_Button  (btn),
      .LCD_VSYNC    (vsync),
      .pattern_sel  (pattern_sel),
      .pattern_upd  (pattern_upd),
      .busy         (busy),
      .LED          (led)
   );

   always @(negedge clk) begin
      if (pattern_upd === 1'b1) upd_total <= upd_total + 1;
   end

   typedef struct {
      string      name;
      int         kind;      // 0 idle, 1 glitch, 2 press, 3 two presses
      int         len;
      int         exp_sel;
      logic [5:0] exp_led;
      int         exp_busy;
      int         exp_upd;
   } vec_t;

   vec_t vecs[7];

   task automatic cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
   endtask

   task automatic hold_btn(input int len);
      btn = 1'b0;
      cycles(len);
      btn = 1'b1;
   endtask

   task automatic vsync_fall();
      vsync = 1'b0;
      cycles(10);
      vsync = 1'b1;
      cycles(20);
   endtask

   // One 200-cycle frame: button activity, then a VSYNC fall near the end
   task automatic run_frame(input int kind, input int len, output int upd_n, output int busy_pre);
      int start;
      int used;
      start = upd_total;
      cycles(20);
      used = 20;
      case (kind)
         1, 2: begin
            hold_btn(len);
            used += len;
         end
         3: begin
            hold_btn(20);
            cycles(25);
            hold_btn(20);
            used += 65;
         end
         default: ;
      endcase
      cycles(170 - used);
      busy_pre = int'(busy);
      vsync_fall();
      upd_n = upd_total - start;
   endtask

   function automatic int model_led(input int sel);
      logic [5:0] one;
      one = 6'd1 << sel;
      return int'(6'h3f ^ one);
   endfunction

   initial begin
      int upd_n;
      int busy_pre;
      int model_sel;
      int kind;
      int len;
      int start;

      vecs[0] = '{"first_press",   2, 20, 1, 6'b111101, 1, 1};
      vecs[1] = '{"glitch8",       1,  8, 1, 6'b111101, 0, 0};
      vecs[2] = '{"press_to_2",    2, 20, 2, 6'b111011, 1, 1};
      vecs[3] = '{"press_to_3",    2, 20, 3, 6'b110111, 1, 1};
      vecs[4] = '{"press_wrap",    2, 20, 0, 6'b111110, 1, 1};
      vecs[5] = '{"double_press",  3,  0, 1, 6'b111101, 1, 1};
      vecs[6] = '{"no_press",      0,  0, 1, 6'b111101, 0, 0};

      cycles(5);
      check("rst_hold_sel",  int'(pattern_sel), 0);
      check("rst_hold_led",  int'(led), int'(6'b111110));
      check("rst_hold_busy", int'(busy), 0);
      rst_n = 1'b1;
      cycles(5);
      check("rst_rel_sel",  int'(pattern_sel), 0);
      check("rst_rel_led",  int'(led), int'(6'b111110));
      check("rst_rel_busy", int'(busy), 0);
      check("rst_rel_upd",  int'(pattern_upd), 0);

`ifdef LCD_AUTO_CYCLE_EN
      for (int i = 0; i < 9; i++) begin
         run_frame(0, 0, upd_n, busy_pre);
         check($sformatf("auto_upd_f%0d", i + 1), upd_n, ((i % 3) == 2) ? 1 : 0);
         check($sformatf("auto_sel_f%0d", i + 1), int'(pattern_sel), (i + 1) / 3);
         check($sformatf("auto_led_f%0d", i + 1), int'(led), model_led((i + 1) / 3));
      end
`else
      for (int i = 0; i < 7; i++) begin
         run_frame(vecs[i].kind, vecs[i].len, upd_n, busy_pre);
         check({vecs[i].name, "_busy"}, busy_pre, vecs[i].exp_busy);
         check({vecs[i].name, "_upd"},  upd_n, vecs[i].exp_upd);
         check({vecs[i].name, "_sel"},  int'(pattern_sel), vecs[i].exp_sel);
         check({vecs[i].name, "_led"},  int'(led), int'(vecs[i].exp_led));
         check({vecs[i].name, "_idle"}, int'(busy), 0);
      end
      model_sel = vecs[6].exp_sel;

      // Stalled panel: armed change waits indefinitely, then commits on the next fall
      start = upd_total;
      hold_btn(20);
      cycles(600);
      check("stall_busy", int'(busy), 1);
      check("stall_sel", int'(pattern_sel), model_sel);
      check("stall_no_upd", upd_total - start, 0);
      vsync_fall();
      model_sel = (model_sel + 1) % NUM_MODES;
      check("stall_commit_sel", int'(pattern_sel), model_sel);
      check("stall_commit_upd", upd_total - start, 1);
      check("stall_commit_busy", int'(busy), 0);

      // Reset while armed discards the pending change
      hold_btn(20);
      cycles(30);
      check("mid_rst_armed", int'(busy), 1);
      rst_n = 1'b0;
      cycles(3);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_sel", int'(pattern_sel), 0);
      check("mid_rst_led", int'(led), int'(6'b111110));
      rst_n = 1'b1;
      cycles(5);
      model_sel = 0;
      for (int i = 0; i < 3; i++) begin
         run_frame(0, 0, upd_n, busy_pre);
         check($sformatf("post_rst_upd_f%0d", i + 1), upd_n, 0);
         check($sformatf("post_rst_sel_f%0d", i + 1), int'(pattern_sel), 0);
      end

      // Randomized frames against a per-frame reference model
      for (int i = 0; i < 16; i++) begin
         kind = int'($urandom_range(0, 3));
         len  = (kind == 1) ? int'($urandom_range(1, 8)) : int'($urandom_range(20, 40));
         run_frame(kind, len, upd_n, busy_pre);
         if (kind >= 2) model_sel = (model_sel + 1) % NUM_MODES;
         check($sformatf("rnd%0d_k%0d_busy", i, kind), busy_pre, (kind >= 2) ? 1 : 0);
         check($sformatf("rnd%0d_k%0d_upd", i, kind), upd_n, (kind >= 2) ? 1 : 0);
         check($sformatf("rnd%0d_k%0d_sel", i, kind), int'(pattern_sel), model_sel);
         check($sformatf("rnd%0d_k%0d_led", i, kind), int'(led), model_led(model_sel));
      end
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
